// File: rtl/pa_fcnvt_pkg.sv
// Shared encodings and constants for the float-to-integer conversion control path.
// Holds the FSM encoding, rounding-mode codes, saturation constants and the operand classifier.
package pa_fcnvt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_TINY = 3'd0,
        CLS_HALF = 3'd1,
        CLS_NORM = 3'd2,
        CLS_BIG  = 3'd3,
        CLS_INF  = 3'd4,
        CLS_NAN  = 3'd5
    } cls_t;

    localparam logic [2:0]  RM_RNE     = 3'd0;
    localparam logic [2:0]  RM_RTZ     = 3'd1;
    localparam logic [2:0]  RM_RDN     = 3'd2;
    localparam logic [2:0]  RM_RUP     = 3'd3;
    localparam logic [2:0]  RM_RMM     = 3'd4;

    localparam logic [31:0] INT_MAX_S  = 32'h7fff_ffff;
    localparam logic [31:0] INT_MIN_S  = 32'h8000_0000;
    localparam logic [31:0] INT_MAX_U  = 32'hffff_ffff;
    localparam logic [7:0]  BIAS       = 8'd127;
    localparam logic [5:0]  SHCNT_HALF = 6'h3f;

    function automatic cls_t classify(input logic [31:0] src);
        logic [7:0] ex;
        cls_t       c;
        ex = src[30:23];
        if (ex == 8'hff)                c = (src[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else if (ex < BIAS - 8'd1)      c = CLS_TINY;
        else if (ex == BIAS - 8'd1)     c = CLS_HALF;
        else if (ex <= BIAS + 8'd31)    c = CLS_NORM;
        else                            c = CLS_BIG;
        return c;
    endfunction

    // Classes whose result does not depend on the shifter output.
    function automatic logic is_special(input cls_t c);
        return (c == CLS_NAN) || (c == CLS_INF) || (c == CLS_BIG) || (c == CLS_TINY);
    endfunction

endpackage

// File: rtl/pa_fcnvt_ftoi_ctrl_if.sv
// Request/response handshake bundle between the FALU issue logic and the ftoi sequencer.
// Master drives the request and accepts the result; slave is the sequencer.
interface pa_fcnvt_ftoi_ctrl_if;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_src;
    logic [2:0]  req_rm;
    logic        req_unsigned;
    logic        resp_vld;
    logic        resp_rdy;
    logic [31:0] resp_data;
    logic        resp_nv;
    logic        resp_nx;

    modport master (
        output req_vld, req_src, req_rm, req_unsigned, resp_rdy,
        input  req_rdy, resp_vld, resp_data, resp_nv, resp_nx
    );

    modport slave (
        input  req_vld, req_src, req_rm, req_unsigned, resp_rdy,
        output req_rdy, resp_vld, resp_data, resp_nv, resp_nx
    );
endinterface

// File: rtl/pa_fcnvt_ftoi_rnd.sv
// Round, saturate and flag generation for single-to-int32 conversion.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module pa_fcnvt_ftoi_rnd
    import pa_fcnvt_pkg::*;
(
    input  cls_t        cls,
    input  logic        sign,
    input  logic        mag_nz,
    input  logic [2:0]  rm,
    input  logic        is_unsigned,
    input  logic [31:0] v_in,
    input  logic [24:0] x_in,
    output logic [31:0] res_data,
    output logic        res_nv,
    output logic        res_nx
);

    logic [31:0] v;
    logic        r;
    logic        s;
    logic        inc;
    logic [32:0] m;
    logic        ovf_cls;
    logic        nx_raw;

    always_comb begin
        v = 32'd0;
        r = 1'b0;
        s = mag_nz;
        if (cls != CLS_TINY) begin
            v = v_in;
            r = x_in[24];
            s = |x_in[23:0];
        end

        case (rm)
            RM_RNE:  inc = r & (s | v[0]);
            RM_RDN:  inc = sign & (r | s);
            RM_RUP:  inc = ~sign & (r | s);
            RM_RMM:  inc = r;
            default: inc = 1'b0;
        endcase

        m       = {1'b0, v} + {32'd0, inc};
        ovf_cls = (cls == CLS_INF) || (cls == CLS_BIG);

        res_data = 32'd0;
        res_nv   = 1'b0;
        nx_raw   = 1'b0;
        if (cls == CLS_NAN) begin
            res_data = is_unsigned ? INT_MAX_U : INT_MAX_S;
            res_nv   = 1'b1;
        end else if (is_unsigned) begin
            if (sign) begin
                // Only a value that rounds to zero is representable.
                if (ovf_cls || (m != 33'd0)) res_nv = 1'b1;
                else                         nx_raw = r | s;
            end else if (ovf_cls || m[32]) begin
                res_data = INT_MAX_U;
                res_nv   = 1'b1;
            end else begin
                res_data = m[31:0];
                nx_raw   = r | s;
            end
        end else if (sign) begin
            if (ovf_cls || (m > {1'b0, INT_MIN_S})) begin
                res_data = INT_MIN_S;
                res_nv   = 1'b1;
            end else begin
                res_data = ~m[31:0] + 32'd1;
                nx_raw   = r | s;
            end
        end else if (ovf_cls || (m > {1'b0, INT_MAX_S})) begin
            res_data = INT_MAX_S;
            res_nv   = 1'b1;
        end else begin
            res_data = m[31:0];
            nx_raw   = r | s;
        end
        res_nx = nx_raw & ~res_nv;
    end

endmodule

// File: rtl/pa_fcnvt_ftoi_ctrl.sv
// FCVT.W.S / FCVT.WU.S sequencer: classify, drive external shifter, round and hold result.
// Latency: 3 cycles from accept; 1 cycle for NaN/Inf/big/tiny when FCNVT_FTOI_FAST_SPECIAL_EN is defined.
// Backpressure: one conversion in flight; result held in DONE until resp_rdy, req_rdy only in IDLE.
module pa_fcnvt_ftoi_ctrl
    import pa_fcnvt_pkg::*;
(
    input  logic                       cpuclk,
    input  logic                       cpurst_b,
    input  logic                       ctrl_flush,
    pa_fcnvt_ftoi_ctrl_if.slave        io,
    output logic [5:0]                 fsh_cnt,
    output logic [23:0]                fsh_src,
    input  logic [31:0]                fsh_i_v_nm,
    input  logic [24:0]                fsh_i_x_nm,
    output logic                       busy
);

    state_t      state_q, state_d;
    logic [31:0] op_src_q;
    logic [2:0]  op_rm_q;
    logic        op_uns_q;
    logic [31:0] v_q;
    logic [24:0] x_q;
    logic [31:0] data_q;
    logic        nv_q, nx_q;

    cls_t        cls_q;
    logic [5:0]  e_lo;
    logic        accept;
    logic        fast;
    logic        load_res;

    logic [31:0] rnd_src;
    logic [2:0]  rnd_rm;
    logic        rnd_uns;
    logic [31:0] rnd_data;
    logic        rnd_nv, rnd_nx;

    assign cls_q  = classify(op_src_q);
    // Low 6 bits of (exp - bias); only used for exponents 0..31.
    assign e_lo   = op_src_q[28:23] - BIAS[5:0];
    assign accept = io.req_vld && (state_q == ST_IDLE) && !ctrl_flush;

    always_comb begin
        fsh_cnt = 6'd0;
        if (state_q == ST_SHIFT) begin
            if (cls_q == CLS_HALF)      fsh_cnt = SHCNT_HALF;
            else if (cls_q == CLS_NORM) fsh_cnt = e_lo;
        end
    end

    assign fsh_src = {op_src_q[30:23] != 8'd0, op_src_q[22:0]};

    always_comb begin
`ifdef FCNVT_FTOI_FAST_SPECIAL_EN
        if (state_q == ST_IDLE) begin
            rnd_src = io.req_src;
            rnd_rm  = io.req_rm;
            rnd_uns = io.req_unsigned;
        end else begin
            rnd_src = op_src_q;
            rnd_rm  = op_rm_q;
            rnd_uns = op_uns_q;
        end
        fast = accept && is_special(classify(io.req_src));
`else
        rnd_src = op_src_q;
        rnd_rm  = op_rm_q;
        rnd_uns = op_uns_q;
        fast    = 1'b0;
`endif
    end

    pa_fcnvt_ftoi_rnd u_rnd (
        .cls         (classify(rnd_src)),
        .sign        (rnd_src[31]),
        .mag_nz      (|rnd_src[30:0]),
        .rm          (rnd_rm),
        .is_unsigned (rnd_uns),
        .v_in        (v_q),
        .x_in        (x_q),
        .res_data    (rnd_data),
        .res_nv      (rnd_nv),
        .res_nx      (rnd_nx)
    );

    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = fast ? ST_DONE : ST_SHIFT;
                    load_res = fast;
                end
            end
            ST_SHIFT: state_d = ST_ROUND;
            ST_ROUND: begin
                state_d  = ST_DONE;
                load_res = 1'b1;
            end
            ST_DONE:  if (io.resp_rdy) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (ctrl_flush) begin
            state_d  = ST_IDLE;
            load_res = 1'b0;
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= ST_IDLE;
            op_src_q <= 32'd0;
            op_rm_q  <= 3'd0;
            op_uns_q <= 1'b0;
            v_q      <= 32'd0;
            x_q      <= 25'd0;
            data_q   <= 32'd0;
            nv_q     <= 1'b0;
            nx_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_src_q <= io.req_src;
                op_rm_q  <= io.req_rm;
                op_uns_q <= io.req_unsigned;
            end
            if (state_q == ST_SHIFT) begin
                v_q <= fsh_i_v_nm;
                x_q <= fsh_i_x_nm;
            end
            if (load_res) begin
                data_q <= rnd_data;
                nv_q   <= rnd_nv;
                nx_q   <= rnd_nx;
            end
        end
    end

    assign io.req_rdy   = (state_q == ST_IDLE);
    assign io.resp_vld  = (state_q == ST_DONE);
    assign io.resp_data = data_q;
    assign io.resp_nv   = nv_q;
    assign io.resp_nx   = nx_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pa_fcnvt_ftoi_ctrl.sv
// Directed bench for pa_fcnvt_ftoi_ctrl with a behavioural normalise shifter.
module tb_pa_fcnvt_ftoi_ctrl;

    logic        cpuclk = 1'b0;
    logic        cpurst_b;
    logic        ctrl_flush;
    logic [5:0]  fsh_cnt;
    logic [23:0] fsh_src;
    logic [31:0] fsh_i_v_nm;
    logic [24:0] fsh_i_x_nm;
    logic        busy;
    logic [80:0] sh_w;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef FCNVT_FTOI_FAST_SPECIAL_EN
    localparam int SPL_LAT = 1;
    localparam int SPL_CNT = -1;
`else
    localparam int SPL_LAT = 3;
    localparam int SPL_CNT = 0;
`endif

    pa_fcnvt_ftoi_ctrl_if io ();

    pa_fcnvt_ftoi_ctrl dut (
        .cpuclk     (cpuclk),
        .cpurst_b   (cpurst_b),
        .ctrl_flush (ctrl_flush),
        .io         (io.slave),
        .fsh_cnt    (fsh_cnt),
        .fsh_src    (fsh_src),
        .fsh_i_v_nm (fsh_i_v_nm),
        .fsh_i_x_nm (fsh_i_x_nm),
        .busy       (busy)
    );

    always #5 cpuclk = ~cpuclk;

    // Value sig * 2^(e-23) with 25 fraction bits: integer in [56:25], fraction in [24:0].
    always_comb begin
        sh_w = {57'd0, fsh_src} << 25;
        if (fsh_cnt == 6'h3f) sh_w = sh_w >> 24;
        else                  sh_w = (sh_w << fsh_cnt) >> 23;
    end
    assign fsh_i_v_nm = sh_w[56:25];
    assign fsh_i_x_nm = sh_w[24:0];

    task automatic step();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] src, input logic [2:0] rm,
                           input logic uns, input logic [31:0] e_data, input logic e_nv,
                           input logic e_nx, input int e_lat, input int e_cnt);
        int lat;
        chk({tag, "_req_rdy"}, 32'(io.req_rdy), 32'd1);
        io.req_vld      = 1'b1;
        io.req_src      = src;
        io.req_rm       = rm;
        io.req_unsigned = uns;
        step();
        io.req_vld = 1'b0;
        io.req_src = 32'd0;
        if (e_cnt >= 0) chk({tag, "_fsh_cnt"}, 32'(fsh_cnt), 32'(e_cnt));
        lat = 1;
        while (!io.resp_vld && lat < 12) begin
            step();
            lat++;
        end
        chk({tag, "_vld"},  32'(io.resp_vld), 32'd1);
        chk({tag, "_lat"},  32'(lat), 32'(e_lat));
        chk({tag, "_data"}, io.resp_data, e_data);
        chk({tag, "_nv"},   32'(io.resp_nv), 32'(e_nv));
        chk({tag, "_nx"},   32'(io.resp_nx), 32'(e_nx));
        io.resp_rdy = 1'b1;
        step();
        io.resp_rdy = 1'b0;
        chk({tag, "_vld_clr"}, 32'(io.resp_vld), 32'd0);
        chk({tag, "_idle"},    32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        cpurst_b        = 1'b0;
        ctrl_flush      = 1'b0;
        io.req_vld      = 1'b0;
        io.req_src      = 32'd0;
        io.req_rm       = 3'd0;
        io.req_unsigned = 1'b0;
        io.resp_rdy     = 1'b0;
        step();
        step();
        chk("rst_vld",  32'(io.resp_vld), 32'd0);
        chk("rst_data", io.resp_data, 32'd0);
        chk("rst_nv",   32'(io.resp_nv), 32'd0);
        chk("rst_nx",   32'(io.resp_nx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy",  32'(io.req_rdy), 32'd1);
        chk("rst_cnt",  32'(fsh_cnt), 32'd0);
        chk("rst_src",  32'(fsh_src), 32'd0);
        cpurst_b = 1'b1;
        step();

        convert("w_rne_2p5",   32'h4020_0000, 3'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1, 3, 1);
        convert("w_rne_1p5",   32'h3FC0_0000, 3'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1, 3, 0);
        convert("w_rne_0p5",   32'h3F00_0000, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 3, 63);
        convert("w_rmm_m0p5",  32'hBF00_0000, 3'd4, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 3, 63);
        convert("w_rtz_min",   32'hCF00_0000, 3'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 3, 31);
        convert("w_rtz_2p31",  32'h4F00_0000, 3'd1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 3, 31);
        convert("wu_rup_max",  32'h4F7F_FFFF, 3'd3, 1'b1, 32'hFFFF_FF00, 1'b0, 1'b0, 3, 31);
        convert("wu_rtz_m0p3", 32'hBE99_999A, 3'd1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, SPL_LAT, SPL_CNT);
        convert("wu_m1",       32'hBF80_0000, 3'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 3, 0);
        convert("w_nan",       32'h7FC0_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, SPL_LAT, SPL_CNT);
        convert("wu_nan",      32'h7FC0_0000, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, SPL_LAT, SPL_CNT);
        convert("w_minf",      32'hFF80_0000, 3'd0, 1'b0, 32'h8000_0000, 1'b1, 1'b0, SPL_LAT, SPL_CNT);

        // Result must stay put while the consumer stalls.
        io.req_vld = 1'b1;
        io.req_src = 32'h4020_0000;
        io.req_rm  = 3'd0;
        io.req_unsigned = 1'b0;
        step();
        io.req_vld = 1'b0;
        lat = 1;
        while (!io.resp_vld && lat < 12) begin
            step();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_vld",  32'(io.resp_vld), 32'd1);
            chk("hold_data", io.resp_data, 32'd2);
            chk("hold_nx",   32'(io.resp_nx), 32'd1);
            chk("hold_rdy",  32'(io.req_rdy), 32'd0);
            step();
        end
        io.resp_rdy = 1'b1;
        step();
        io.resp_rdy = 1'b0;
        chk("hold_release", 32'(io.resp_vld), 32'd0);

        // Flush in SHIFT, then flush colliding with a request in IDLE.
        io.req_vld = 1'b1;
        io.req_src = 32'hBF00_0000;
        step();
        chk("fl_busy_shift", 32'(busy), 32'd1);
        ctrl_flush = 1'b1;
        step();
        chk("fl_idle",    32'(busy), 32'd0);
        chk("fl_no_vld",  32'(io.resp_vld), 32'd0);
        chk("fl_req_rdy", 32'(io.req_rdy), 32'd1);
        step();
        chk("fl_req_blocked", 32'(busy), 32'd0);
        ctrl_flush = 1'b0;
        io.req_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_quiet", 32'(io.resp_vld), 32'd0);
        end

        // Asynchronous reset in ROUND; result register holds 2 from the stall test.
        io.req_vld = 1'b1;
        io.req_src = 32'h4020_0000;
        step();
        io.req_vld = 1'b0;
        step();
        chk("mr_busy", 32'(busy), 32'd1);
        cpurst_b = 1'b0;
        #1;
        chk("mr_vld",  32'(io.resp_vld), 32'd0);
        chk("mr_data", io.resp_data, 32'd0);
        chk("mr_nv",   32'(io.resp_nv), 32'd0);
        chk("mr_nx",   32'(io.resp_nx), 32'd0);
        chk("mr_busy0", 32'(busy), 32'd0);
        chk("mr_cnt",  32'(fsh_cnt), 32'd0);
        chk("mr_src",  32'(fsh_src), 32'd0);
        step();
        cpurst_b = 1'b1;
        step();
        convert("post_rst", 32'h4020_0000, 3'd3, 1'b0, 32'h0000_0003, 1'b0, 1'b1, 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
